// File: rtl/mems_dac_pkg.sv
// Purpose: shared constants, command words and FSM state type for the MEMS DAC sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package mems_dac_pkg;

    localparam int CMD_W   = 24;
    localparam int FIELD_W = 16;   // data field of a command word; deltas are left-justified into it

    localparam logic [3:0] CMD_WRITE            = 4'b0000;
    localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'b0010;

    localparam logic [CMD_W-1:0] SOFT_RESET_WORD = 24'h280001;
    localparam logic [CMD_W-1:0] LDAC_SETUP_WORD = 24'h373FF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_RST,
        ST_INIT_LDAC,
        ST_CH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mems_dac_cmd_fmt.sv
// Purpose: builds a 24-bit DAC command word from command nibble, channel address and delta.
// Latency: combinational.
// Backpressure: none.
// Ports: cmd (4b command), ch (4b address), delta (DATA_W, left-justified into 16b), word (24b out).
module mems_dac_cmd_fmt
    import mems_dac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        cmd,
    input  logic [3:0]        ch,
    input  logic [DATA_W-1:0] delta,
    output logic [CMD_W-1:0]  word
);

    logic [FIELD_W-1:0] field;

    always_comb begin
        field = '0;
        field[FIELD_W-1 -: DATA_W] = delta;
        word = {cmd, ch, field};
    end

endmodule

// File: rtl/mems_dac_sequencer.sv
// Purpose: snapshots NUM_CH deltas on start and emits one frame of DAC command words (optional init prefix).
// Latency: first word valid one cycle after start; one word per cycle while cmd_ready is high.
// Backpressure: cmd_valid/cmd_data held stable until cmd_ready; frame stalls without loss.
// Ports: clk, rst (sync active-high), start, reinit, skip_unchanged, delta[NUM_CH*DATA_W],
//        cmd_data/cmd_valid/cmd_ready (word handshake), busy, done (1-cycle completion pulse).
module mems_dac_sequencer
    import mems_dac_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     reinit,
    input  logic                     skip_unchanged,
    input  logic [NUM_CH*DATA_W-1:0] delta,
    output logic [CMD_W-1:0]         cmd_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    state_t                         state_q, state_nx;
    logic [3:0]                     ch_q, ch_nx;
    logic [NUM_CH-1:0][DATA_W-1:0]  shadow_q, shadow_eff, last_sent_q;
    logic [NUM_CH-1:0]              sent_valid_q, send_mask;
    logic                           skip_q, skip_eff;
    logic                           init_pending_q;
    logic                           start_acc, xfer;
    logic                           valid_nx;
    logic [CMD_W-1:0]               word_nx, fmt_word;
    logic [DATA_W-1:0]              sel_delta;
    logic [3:0]                     sel_cmd;

    assign start_acc = start && (state_q == ST_IDLE);
    assign xfer      = cmd_valid && cmd_ready;

    // Lowest channel >= from that is to be sent; the last channel is always in the mask.
    function automatic logic [3:0] first_set(input logic [NUM_CH-1:0] mask, input int from);
        logic [3:0] r;
        r = LAST_CH;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (k >= from)) r = 4'(k);
        end
        return r;
    endfunction

    // In the start cycle the shadow is not loaded yet, so decisions look at the live inputs.
    always_comb begin
        shadow_eff = start_acc ? delta : shadow_q;
        skip_eff   = start_acc ? skip_unchanged : skip_q;
        for (int k = 0; k < NUM_CH; k++) begin
            send_mask[k] = !skip_eff || !sent_valid_q[k] ||
                           (shadow_eff[k] != last_sent_q[k]) || (k == NUM_CH - 1);
        end
    end

    // State register plus frame datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            shadow_q       <= '0;
            skip_q         <= 1'b0;
            last_sent_q    <= '0;
            sent_valid_q   <= '0;
            init_pending_q <= 1'b1;
            cmd_valid      <= 1'b0;
            cmd_data       <= '0;
        end else begin
            state_q   <= state_nx;
            ch_q      <= ch_nx;
            cmd_valid <= valid_nx;
            cmd_data  <= word_nx;
            if (start_acc) begin
                shadow_q <= delta;
                skip_q   <= skip_unchanged;
            end
            if (xfer && (state_q == ST_CH)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_q == 4'(k)) begin
                        last_sent_q[k]  <= shadow_q[k];
                        sent_valid_q[k] <= 1'b1;
                    end
                end
            end
            // A reinit coinciding with the LDAC transfer must still apply to the next frame.
            if (reinit)
                init_pending_q <= 1'b1;
            else if (xfer && (state_q == ST_INIT_LDAC))
                init_pending_q <= 1'b0;
        end
    end

    // Next-state logic; the first channel is chosen at start even when init words come first,
    // since nothing that feeds the mask changes during the init words.
    always_comb begin
        state_nx = state_q;
        ch_nx    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx = init_pending_q ? ST_INIT_RST : ST_CH;
                    ch_nx    = first_set(send_mask, 0);
                end
            end
            ST_INIT_RST:  if (xfer) state_nx = ST_INIT_LDAC;
            ST_INIT_LDAC: if (xfer) state_nx = ST_CH;
            ST_CH: begin
                if (xfer) begin
                    if (ch_q == LAST_CH) state_nx = ST_DONE;
                    else                 ch_nx    = first_set(send_mask, int'(ch_q) + 1);
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    mems_dac_cmd_fmt #(.DATA_W(DATA_W)) u_fmt (
        .cmd   (sel_cmd),
        .ch    (ch_nx),
        .delta (sel_delta),
        .word  (fmt_word)
    );

    // Output logic: the word for the next state is computed here and registered above,
    // so cmd_data is steady while the handshake stalls.
    always_comb begin
        sel_delta = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_nx == 4'(k)) sel_delta = shadow_eff[k];
        end
        sel_cmd  = (ch_nx == LAST_CH) ? CMD_WRITE_UPDATE_ALL : CMD_WRITE;
        valid_nx = 1'b0;
        word_nx  = '0;
        case (state_nx)
            ST_INIT_RST:  begin valid_nx = 1'b1; word_nx = SOFT_RESET_WORD; end
            ST_INIT_LDAC: begin valid_nx = 1'b1; word_nx = LDAC_SETUP_WORD; end
            ST_CH:        begin valid_nx = 1'b1; word_nx = fmt_word;        end
            default:      begin valid_nx = 1'b0; word_nx = '0;              end
        endcase
        busy = (state_q == ST_INIT_RST) || (state_q == ST_INIT_LDAC) || (state_q == ST_CH);
        done = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_mems_dac_sequencer.sv
// Purpose: self-checking bench for mems_dac_sequencer against a frame-level word-list model.
// Latency: n/a.
// Backpressure: cmd_ready driven always-high, random, or in a 1-0-0-1 pattern.
module tb_mems_dac_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, reinit, skip_unchanged, cmd_ready;
    logic [31:0] delta;
    logic [23:0] cmd_data;
    logic        cmd_valid, busy, done;

    int checks = 0;
    int errors = 0;

    // Model: expected word list of the current frame plus what the DAC was last told.
    logic [23:0] exp_q[$];
    bit          m_init;
    logic [7:0]  m_last[4];
    bit          m_sent[4];
    logic [31:0] cur_d;

    mems_dac_sequencer #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .reinit         (reinit),
        .skip_unchanged (skip_unchanged),
        .delta          (delta),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_last[k] = 8'h00;
            m_sent[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic build_frame(input logic [31:0] d, input logic sk);
        logic [7:0] v;
        exp_q.delete();
        if (m_init) begin
            exp_q.push_back(24'h280001);
            exp_q.push_back(24'h373FF0);
            m_init = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            v = d[k*8 +: 8];
            if (!sk || !m_sent[k] || (v != m_last[k]) || (k == 3)) begin
                exp_q.push_back(((k == 3 ? 24'h2 : 24'h0) << 20) | (24'(k) << 16) | (24'(v) << 8));
                m_last[k] = v;
                m_sent[k] = 1'b1;
            end
        end
    endtask

    // Called at a negedge with the DUT idle. rmode: 0 ready high, 1 random, 2 pattern 1-0-0-1.
    // mid_act: 0 none, 1 new delta + extra start + reinit, 2 reset, applied once xfers == mid_idx.
    task automatic run_frame(input logic [31:0] d, input logic sk, input int rmode,
                             input int mid_idx, input int mid_act);
        int xf  = 0;
        int cyc = 0;
        bit mid_done = 1'b0;
        build_frame(d, sk);
        delta = d;
        skip_unchanged = sk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        skip_unchanged = 1'($urandom_range(0, 1));
        while (exp_q.size() > 0 && cyc < 200) begin
            start  = 1'b0;
            reinit = 1'b0;
            check("valid_in_frame", cmd_valid, 1);
            check("busy_in_frame", busy, 1);
            check("done_in_frame", done, 0);
            check("word", cmd_data, exp_q[0]);
            if (mid_act != 0 && !mid_done && xf == mid_idx) begin
                mid_done = 1'b1;
                if (mid_act == 1) begin
                    delta  = $urandom;
                    start  = 1'b1;
                    reinit = 1'b1;
                    m_init = 1'b1;
                end else begin
                    rst = 1'b1;
                    cmd_ready = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    check("rst_valid", cmd_valid, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_data", cmd_data, 0);
                    model_reset();
                    return;
                end
            end
            case (rmode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = 1'($urandom_range(0, 1));
                default: cmd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            if (cmd_ready) begin
                void'(exp_q.pop_front());
                xf++;
            end
            cyc++;
            @(negedge clk);
        end
        start  = 1'b0;
        reinit = 1'b0;
        check("frame_timeout", exp_q.size(), 0);
        // DONE cycle: also poke start, which must be ignored.
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", cmd_valid, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", cmd_valid, 0);
    endtask

    initial begin
        logic [31:0] nd;
        rst = 1'b1;
        start = 1'b0;
        reinit = 1'b0;
        skip_unchanged = 1'b0;
        cmd_ready = 1'b0;
        delta = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", cmd_valid, 0);
        check("reset_data", cmd_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Default frame with init words, then a repeat without skipping.
        run_frame(32'h40302010, 1'b0, 0, -1, 0);
        run_frame(32'h40302010, 1'b0, 0, -1, 0);
        // Skip mode: only channel 1 changed, then nothing changed (minimum frame).
        run_frame(32'h40305510, 1'b1, 0, -1, 0);
        run_frame(32'h40305510, 1'b1, 0, -1, 0);
        // Stalling handshake.
        run_frame($urandom, 1'b0, 2, -1, 0);
        // Mid-frame delta change, extra start and reinit; next frame re-sends init words.
        run_frame($urandom, 1'b0, 1, 2, 1);
        cur_d = $urandom;
        run_frame(cur_d, 1'b1, 0, -1, 0);
        // Reset during the third word, then a skip-mode frame that must resend everything.
        run_frame(cur_d, 1'b0, 0, 2, 2);
        @(negedge clk);
        run_frame(cur_d, 1'b1, 0, -1, 0);

        // Random frames with partially changed deltas.
        for (int i = 0; i < 20; i++) begin
            nd = cur_d;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) nd[k*8 +: 8] = 8'($urandom);
            end
            cur_d = nd;
            run_frame(nd, 1'($urandom_range(0, 1)), 1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
